pwm_gen_apb: RTL and testbench

//  APB3-programmable multi-channel PWM generator that drives the top-level pwm_io pads.
//  One shared prescaler and period counter; a per-channel duty compare produces each output.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_gen_apb_channel.sv | 43 ++++
 rtl/pwm_gen_apb.sv | 139 +++++++++++++
 tb/tb_pwm_gen_apb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared register map, CTRL bit positions and counter type for the APB PWM generator.
package pwm_pkg;
    localparam int CNT_W_DFLT = 16;
    typedef logic [CNT_W_DFLT-1:0] cnt_t;

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_PRESC  = 6'h04;
    localparam logic [5:0] ADDR_PERIOD = 6'h08;
    localparam logic [5:0] ADDR_STATUS = 6'h0C;
    localparam logic [5:0] ADDR_DUTY0  = 6'h10;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_CHEN = 8;
endpackage

// File: rtl/pwm_gen_apb_channel.sv
// One PWM channel: DUTY shadow/active pair and the registered compare output.
// The active duty reloads at the period wrap, or continuously while the block is disabled.
module pwm_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             wrap_i,
    input  logic             en_i,
    input  logic             chen_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wdata_i,
    output logic [CNT_W-1:0] duty_o,
    output logic             pwm_o
);
    import pwm_pkg::*;

    logic [CNT_W-1:0] duty_q, duty_d, act_q, act_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        duty_d = wr_i ? wdata_i : duty_q;
        act_d  = (!en_i || wrap_i) ? duty_q : act_q;
        pwm_d  = en_i && chen_i && (cnt_i < act_q);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            duty_q <= '0;
            act_q  <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            act_q  <= act_d;
            pwm_q  <= pwm_d;
        end
    end

    // Gating with the live enables forces the pad low the moment EN/CHEN drop.
    assign duty_o = duty_q;
    assign pwm_o  = pwm_q & en_i & chen_i;
endmodule

// File: rtl/pwm_gen_apb.sv
// APB3 multi-channel PWM: register decode, shared prescaler and period counter, wrap FLAG/IRQ.
// Zero-wait-state bus; PWM outputs are registered one clock behind the counter.
module pwm_gen_apb #(
    parameter int NCH     = 3,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            psel_i,
    input  logic            penable_i,
    input  logic            pwrite_i,
    input  logic [5:0]      paddr_i,
    input  logic [31:0]     pwdata_i,
    output logic [31:0]     prdata_o,
    output logic            pready_o,
    output logic            pslverr_o,
    output logic [NCH-1:0]  pwm_o,
    output logic [NCH-1:0]  pwm_oe_o,
    output logic            period_irq_o
);
    import pwm_pkg::*;

    logic               aligned, is_duty, mapped, wr_en, tick, wrap;
    logic [5:0]         duty_off;
    logic [3:0]         duty_idx;
    logic               en_q, en_d, ie_q, ie_d, flag_q, flag_d;
    logic [NCH-1:0]     chen_q, chen_d, duty_wr;
    logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   period_q, period_d, period_act_q, period_act_d, cnt_q, cnt_d;
    logic [CNT_W-1:0]   duty_rd [NCH];
    logic [31:0]        rdata;
    logic               unused_bits;

    assign aligned  = (paddr_i[1:0] == 2'b00);
    assign duty_off = paddr_i - ADDR_DUTY0;
    assign duty_idx = duty_off[5:2];
    assign is_duty  = aligned && (paddr_i >= ADDR_DUTY0) && (int'(duty_idx) < NCH);
    assign mapped   = aligned && (paddr_i == ADDR_CTRL || paddr_i == ADDR_PRESC ||
                                  paddr_i == ADDR_PERIOD || paddr_i == ADDR_STATUS || is_duty);
    assign wr_en    = psel_i && penable_i && pwrite_i && mapped;
    assign unused_bits = ^{pwdata_i, duty_off[1:0]};

    always_comb begin
        en_d     = en_q;
        ie_d     = ie_q;
        chen_d   = chen_q;
        presc_d  = presc_q;
        period_d = period_q;
        if (wr_en && paddr_i == ADDR_CTRL) begin
            en_d   = pwdata_i[CTRL_EN];
            ie_d   = pwdata_i[CTRL_IE];
            chen_d = pwdata_i[CTRL_CHEN +: NCH];
        end
        if (wr_en && paddr_i == ADDR_PRESC)  presc_d  = pwdata_i[PRESC_W-1:0];
        if (wr_en && paddr_i == ADDR_PERIOD) period_d = pwdata_i[CNT_W-1:0];
        // A wrap in the same cycle as the W1C wins, so no wrap event is lost.
        flag_d = wrap | (flag_q & ~(wr_en && paddr_i == ADDR_STATUS && pwdata_i[0]));
        for (int i = 0; i < NCH; i++) duty_wr[i] = wr_en && is_duty && (duty_idx == 4'(i));
    end

    assign tick = (pcnt_q == presc_q);
    assign wrap = en_q && tick && (cnt_q == period_act_q);

    always_comb begin
        pcnt_d       = '0;
        cnt_d        = '0;
        period_act_d = period_q;
        if (en_q) begin
            // A prescaler count stranded above a freshly lowered PRESC restarts from zero.
            pcnt_d       = (pcnt_q >= presc_q) ? '0 : pcnt_q + PRESC_W'(1);
            cnt_d        = tick ? (wrap ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
            period_act_d = wrap ? period_q : period_act_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en_q         <= 1'b0;
            ie_q         <= 1'b0;
            flag_q       <= 1'b0;
            chen_q       <= '0;
            presc_q      <= '0;
            pcnt_q       <= '0;
            period_q     <= '0;
            period_act_q <= '0;
            cnt_q        <= '0;
        end else begin
            en_q         <= en_d;
            ie_q         <= ie_d;
            flag_q       <= flag_d;
            chen_q       <= chen_d;
            presc_q      <= presc_d;
            pcnt_q       <= pcnt_d;
            period_q     <= period_d;
            period_act_q <= period_act_d;
            cnt_q        <= cnt_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .cnt_i   (cnt_q),
            .wrap_i  (wrap),
            .en_i    (en_q),
            .chen_i  (chen_q[i]),
            .wr_i    (duty_wr[i]),
            .wdata_i (pwdata_i[CNT_W-1:0]),
            .duty_o  (duty_rd[i]),
            .pwm_o   (pwm_o[i])
        );
    end

    always_comb begin
        rdata = '0;
        case (paddr_i)
            ADDR_CTRL: begin
                rdata[CTRL_EN]          = en_q;
                rdata[CTRL_IE]          = ie_q;
                rdata[CTRL_CHEN +: NCH] = chen_q;
            end
            ADDR_PRESC:  rdata[PRESC_W-1:0] = presc_q;
            ADDR_PERIOD: rdata[CNT_W-1:0]   = period_q;
            ADDR_STATUS: rdata[0]           = flag_q;
            default: begin
                for (int i = 0; i < NCH; i++)
                    if (is_duty && duty_idx == 4'(i)) rdata[CNT_W-1:0] = duty_rd[i];
            end
        endcase
    end

    assign prdata_o     = (psel_i && !pwrite_i && mapped) ? rdata : '0;
    assign pready_o     = 1'b1;
    assign pslverr_o    = psel_i && penable_i && !mapped;
    assign pwm_oe_o     = chen_q & {NCH{en_q}};
    assign period_irq_o = flag_q & ie_q;
endmodule

// File: tb/tb_pwm_gen_apb.sv
// Directed bench for pwm_gen_apb: waveform shape, shadow timing, FLAG/IRQ, bus errors, reset.
module tb_pwm_gen_apb;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [5:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr, irq;
    logic [2:0]  pwm, pwm_oe;
    int          checks = 0, errors = 0;

    pwm_gen_apb #(.NCH(3), .CNT_W(16), .PRESC_W(8)) dut (
        .clk_i(clk), .rstn_i(rstn), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
        .pslverr_o(pslverr), .pwm_o(pwm), .pwm_oe_o(pwm_oe), .period_irq_o(irq)
    );

    initial forever #5 clk = ~clk;

    // Called on a falling edge; commits on the second rising edge and returns on the next falling edge.
    task automatic apb_write(input logic [5:0] a, input logic [31:0] d, output logic err);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        @(posedge clk); @(negedge clk);
        penable = 1'b1;
        #1 err = pslverr;
        @(posedge clk); @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [5:0] a, output logic [31:0] d, output logic err);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        @(posedge clk); @(negedge clk);
        penable = 1'b1;
        #1 d = prdata; err = pslverr;
        @(posedge clk); @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        logic [5:0] addrs [5] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10};
        checks++;
        if ({pwm, pwm_oe, irq, pslverr, prdata} !== '0 || pready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: pwm=%b oe=%b irq=%b slverr=%b prdata=%h pready=%b, need all 0 and pready 1",
                     pwm, pwm_oe, irq, pslverr, prdata, pready);
        end
        foreach (addrs[i]) begin
            apb_read(addrs[i], d, e);
            checks++;
            if (d !== 32'h0 || e !== 1'b0) begin
                errors++;
                $display("FAIL reset_read_%h: data=%h err=%b, need 0/0", addrs[i], d, e);
            end
        end
    endtask

    task automatic test_basic();
        logic e; logic exp_pwm, exp_irq;
        apb_write(6'h08, 32'd9, e);
        apb_write(6'h10, 32'd3, e);
        apb_write(6'h00, 32'h103, e);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_pwm = ((k - 1) % 10) < 3;
            exp_irq = (k >= 10);
            checks++;
            if (pwm[0] !== exp_pwm || irq !== exp_irq || pwm_oe !== 3'b001) begin
                errors++;
                $display("FAIL basic_cyc%0d: pwm0=%b irq=%b oe=%b, need %b %b 001", k, pwm[0], irq, pwm_oe, exp_pwm, exp_irq);
            end
        end
    endtask

    // Continues from cycle 20 of test_basic; the new duty lands at the wrap on cycle 30.
    task automatic test_mid_write();
        logic e; logic exp_pwm; int duty;
        apb_write(6'h10, 32'd7, e);
        for (int k = 23; k <= 50; k++) begin
            @(negedge clk);
            duty = (k >= 31) ? 7 : 3;
            exp_pwm = ((k - 1) % 10) < duty;
            checks++;
            if (pwm[0] !== exp_pwm) begin
                errors++;
                $display("FAIL midwrite_cyc%0d: pwm0=%b, need %b", k, pwm[0], exp_pwm);
            end
        end
    endtask

    task automatic test_duty_edges();
        logic e; logic [31:0] d;
        apb_write(6'h00, 32'h0, e);
        checks++;
        if (pwm !== 3'b000 || pwm_oe !== 3'b000) begin
            errors++;
            $display("FAIL disable_outputs: pwm=%b oe=%b, need 000 000", pwm, pwm_oe);
        end
        apb_write(6'h14, 32'd0, e);
        apb_write(6'h18, 32'd10, e);
        apb_read(6'h18, d, e);
        checks++;
        if (d !== 32'd10) begin
            errors++;
            $display("FAIL duty2_readback: got %0d, need 10", d);
        end
        apb_write(6'h00, 32'h703, e);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            checks++;
            if (pwm[2:1] !== 2'b10 || pwm_oe !== 3'b111) begin
                errors++;
                $display("FAIL duty_edges_cyc%0d: pwm[2:1]=%b oe=%b, need 10 111", k, pwm[2:1], pwm_oe);
            end
        end
    endtask

    task automatic test_presc();
        logic e; logic exp_pwm;
        apb_write(6'h00, 32'h0, e);
        apb_write(6'h04, 32'd1, e);
        apb_write(6'h08, 32'd4, e);
        apb_write(6'h10, 32'd2, e);
        apb_write(6'h00, 32'h101, e);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            exp_pwm = ((k - 1) % 10) < 4;
            checks++;
            if (pwm[0] !== exp_pwm) begin
                errors++;
                $display("FAIL presc_cyc%0d: pwm0=%b, need %b", k, pwm[0], exp_pwm);
            end
        end
        apb_write(6'h00, 32'h100, e);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (pwm !== 3'b000 || pwm_oe !== 3'b000) begin
                errors++;
                $display("FAIL en_fall_cyc%0d: pwm=%b oe=%b, need 000 000", k, pwm, pwm_oe);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_irq_and_reset();
        logic e; logic [31:0] d; logic exp_irq;
        logic [5:0] addrs [5] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10};
        apb_write(6'h0C, 32'h1, e);
        apb_read(6'h0C, d, e);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL flag_cleared: status=%h, need 0", d);
        end
        apb_write(6'h04, 32'd0, e);
        apb_write(6'h08, 32'd9, e);
        apb_write(6'h10, 32'd3, e);
        apb_write(6'h00, 32'h103, e);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            exp_irq = (k >= 10);
            checks++;
            if (irq !== exp_irq) begin
                errors++;
                $display("FAIL irq_cyc%0d: irq=%b, need %b", k, irq, exp_irq);
            end
        end
        apb_write(6'h0C, 32'h1, e);   // commits on the wrap edge (cycle 20)
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_on_wrap: irq=%b, need 1", irq);
        end
        apb_write(6'h0C, 32'h1, e);   // commits on cycle 22, no wrap
        checks++;
        if (irq !== 1'b0 || pwm[0] !== 1'b1) begin
            errors++;
            $display("FAIL w1c_plain: irq=%b pwm0=%b, need 0 1", irq, pwm[0]);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (pwm !== 3'b000 || pwm_oe !== 3'b000 || irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pwm=%b oe=%b irq=%b, need 000 000 0", pwm, pwm_oe, irq);
        end
        @(negedge clk);
        rstn = 1'b1;
        foreach (addrs[i]) begin
            apb_read(addrs[i], d, e);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL post_reset_read_%h: data=%h, need 0", addrs[i], d);
            end
        end
    endtask

    task automatic test_slverr();
        logic e; logic [31:0] d;
        apb_write(6'h00, 32'h102, e);
        apb_write(6'h08, 32'h1234, e);
        apb_write(6'h10, 32'h55, e);
        apb_write(6'h3C, 32'hFFFF_FFFF, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL slverr_write: err=%b, need 1", e);
        end
        apb_read(6'h3C, d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b1) begin
            errors++;
            $display("FAIL slverr_read: data=%h err=%b, need 0 1", d, e);
        end
        apb_read(6'h1C, d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b1) begin
            errors++;
            $display("FAIL duty3_unmapped: data=%h err=%b, need 0 1", d, e);
        end
        apb_read(6'h00, d, e);
        checks++;
        if (d !== 32'h102 || e !== 1'b0) begin
            errors++;
            $display("FAIL ctrl_kept: data=%h err=%b, need 102 0", d, e);
        end
        apb_read(6'h08, d, e);
        checks++;
        if (d !== 32'h1234) begin
            errors++;
            $display("FAIL period_kept: data=%h, need 1234", d);
        end
        apb_read(6'h10, d, e);
        checks++;
        if (d !== 32'h55) begin
            errors++;
            $display("FAIL duty0_kept: data=%h, need 55", d);
        end
        apb_read(6'h04, d, e);
        checks++;
        if (d !== 32'h0 || pwm !== 3'b000) begin
            errors++;
            $display("FAIL presc_kept: data=%h pwm=%b, need 0 000", d, pwm);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        test_reset();
        test_basic();
        test_mid_write();
        test_duty_edges();
        test_presc();
        test_irq_and_reset();
        test_slverr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
